ifu_fetch: RTL

Instruction fetch stage, directly upstream of decode (idu).
- Owns the architectural PC.
- Issues word fetches to instruction memory over a valid/ready request channel and accepts the returned instruction word.
- Presents one instruction plus its PC to decode over a valid/ready handshake.
- Handles control-flow redirects (discards in-flight fetches) and a halt request raised when decode sees ebreak.

---
 rtl/npc_pkg.sv | 18 +
 rtl/ifu_ctrl.sv | 66 ++++++
 rtl/ifu_fetch.sv | 76 +++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC, address width.
// Imported by the fetch top and its control FSM.
package npc_pkg;

  localparam int          XLEN          = 64;
  localparam logic [63:0] RESET_PC_DFLT = 64'h8000_0000;
  localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FLUSH,
    HALT
  } ifu_state_t;

endpackage

// File: rtl/ifu_ctrl.sv
// Fetch FSM next-state/output decode; purely combinational, registers live in ifu_fetch.
// Request stalls in REQ until req_ready; an instruction is held in HOLD until inst_ready.
module ifu_ctrl
  import npc_pkg::*;
(
  input  ifu_state_t state,
  input  logic       stop,
  input  logic       req_ready,
  input  logic       resp_valid,
  input  logic       inst_ready,
  input  logic       redirect_valid,
  output ifu_state_t next_state,
  output logic       req_valid,
  output logic       inst_valid,
  output logic       halted,
  output logic       capture,
  output logic       deliver,
  output logic       pc_redirect,
  output logic       pc_advance
);

  ifu_state_t after_xfer;

  assign req_valid  = (state == REQ);
  assign inst_valid = (state == HOLD);
  assign halted     = (state == HALT);

  // Where to go once nothing is outstanding: a pending halt beats a new request.
  assign after_xfer = stop ? HALT : REQ;

  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    deliver     = 1'b0;
    pc_redirect = redirect_valid && (state != HALT);
    case (state)
      IDLE:  next_state = REQ;
      REQ: begin
        if (req_ready)  next_state = redirect_valid ? FLUSH : WAIT;
        else if (stop)  next_state = HALT;
      end
      WAIT: begin
        if (redirect_valid) begin
          next_state = resp_valid ? after_xfer : FLUSH;
        end else if (resp_valid) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          deliver    = 1'b1;
          next_state = after_xfer;
        end else if (redirect_valid) begin
          next_state = after_xfer;
        end
      end
      FLUSH: if (resp_valid) next_state = after_xfer;
      HALT:  next_state = HALT;
      default: next_state = IDLE;
    endcase
    // A delivery in the same cycle as a redirect still counts, but the PC follows the redirect.
    pc_advance = deliver && !redirect_valid;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, one outstanding memory fetch, one-entry buffer to decode.
// Best case one instruction per 3 cycles; stalls on req_ready, waits on resp_valid, holds on inst_ready.
module ifu_fetch #(
  parameter int          XLEN     = npc_pkg::XLEN,
  parameter logic [63:0] RESET_PC = npc_pkg::RESET_PC_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [31:0]     resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic [63:0]     fetch_cnt
);
  import npc_pkg::*;

  ifu_state_t      state;
  ifu_state_t      next_state;
  logic [XLEN-1:0] pc;
  logic            halt_pend;
  logic            capture;
  logic            deliver;
  logic            pc_redirect;
  logic            pc_advance;

  assign req_addr = pc;

  ifu_ctrl u_ctrl (
    .state          (state),
    .stop           (halt | halt_pend),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .next_state     (next_state),
    .req_valid      (req_valid),
    .inst_valid     (inst_valid),
    .halted         (halted),
    .capture        (capture),
    .deliver        (deliver),
    .pc_redirect    (pc_redirect),
    .pc_advance     (pc_advance)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC[XLEN-1:0];
      halt_pend <= 1'b0;
      inst      <= 32'd0;
      inst_pc   <= '0;
      fetch_cnt <= 64'd0;
    end else begin
      state     <= next_state;
      halt_pend <= halt_pend | halt;
      // Redirect targets are word aligned; the low two bits are discarded.
      if (pc_redirect)     pc <= redirect_pc & ~XLEN'(3);
      else if (pc_advance) pc <= pc + XLEN'(4);
      if (capture) begin
        inst    <= resp_data;
        inst_pc <= pc;
      end
      if (deliver) fetch_cnt <= fetch_cnt + 64'd1;
    end
  end

endmodule
